// File: rtl/sht40_sequencer.sv
// sht40_sequencer
//   Runs one SHT40 measurement per `start` pulse: a 1-byte command write, a
//   conversion wait, then a 6-byte read. Each data word's CRC is checked, and
//   the result is presented as raw temperature/humidity words or an error code.
//
// Build option:
//   SHT40_CRC_CHECK_EN  defined   -> CRC bytes are checked; a mismatch gives err=2.
//                       undefined -> CRC bytes are discarded and every full read
//                                    is accepted (err never takes the value 2).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle request for a measurement (honoured in IDLE only)
//   busy                  high from the cycle after an accepted start until IDLE
//   m_req/m_rw/m_addr/
//   m_wdata/m_nbytes      transaction request to the byte-level I2C master
//   m_ack                 master accepted the request
//   m_rx_valid/m_rx_data  received byte strobe and data
//   m_done/m_nack         transaction ended with STOP / sensor NACKed
//   temp_raw/hum_raw      last good words (MSB first on the bus)
//   data_valid            one-cycle strobe when temp_raw/hum_raw update
//   err                   0 none, 1 NACK, 2 CRC, 3 timeout/short read (latched)

module sht40_sequencer #(
    parameter logic [6:0] SENSOR_ADDR    = 7'h44,
    parameter logic [7:0] MEAS_CMD       = 8'hFD,
    parameter int         WAIT_CYCLES    = 200000,
    parameter int         TIMEOUT_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        m_req,
    output logic        m_rw,
    output logic [6:0]  m_addr,
    output logic [7:0]  m_wdata,
    output logic [2:0]  m_nbytes,
    input  logic        m_ack,
    input  logic        m_rx_valid,
    input  logic [7:0]  m_rx_data,
    input  logic        m_done,
    input  logic        m_nack,
    output logic [15:0] temp_raw,
    output logic [15:0] hum_raw,
    output logic        data_valid,
    output logic [1:0]  err
);

    localparam int TO_W = 12;
    // The wait counter only ever holds WAIT_CYCLES-1 down to 0.
    localparam int WC_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_REQ    = 3'd1;
    localparam logic [2:0] WR_WAIT   = 3'd2;
    localparam logic [2:0] MEAS_WAIT = 3'd3;
    localparam logic [2:0] RD_REQ    = 3'd4;
    localparam logic [2:0] RD_DATA   = 3'd5;
    localparam logic [2:0] CHECK     = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_NACK  = 2'd1;
    localparam logic [1:0] ERR_CRC   = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    logic [2:0]      state;
    logic [2:0]      idx;
    logic [WC_W-1:0] wait_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      t_hi, t_lo, h_hi, h_lo;

    logic            rx_take;
    logic [2:0]      idx_nxt;
    logic            crc_ok;
    logic            to_hit;

    assign m_addr = SENSOR_ADDR;

    // Bytes beyond the sixth are dropped; the index saturates at 6.
    assign rx_take = (state == RD_DATA) && m_rx_valid && (idx != 3'd6);
    assign idx_nxt = rx_take ? idx + 3'd1 : idx;
    assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYCLES));

`ifdef SHT40_CRC_CHECK_EN
    logic [7:0] t_crc, h_crc;
    logic [7:0] h_crc_now;

    // CRC-8, poly 0x31, init 0xFF, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [15:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            c = (c[7] ^ d[i]) ? ((c << 1) ^ 8'h31) : (c << 1);
        end
        return c;
    endfunction

    // The final CRC byte may arrive in the same cycle as m_done, so it is
    // taken straight from the bus when that happens.
    assign h_crc_now = (rx_take && (idx == 3'd5)) ? m_rx_data : h_crc;
    assign crc_ok    = (crc8({t_hi, t_lo}) == t_crc) &&
                       (crc8({h_hi, h_lo}) == h_crc_now);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_crc <= 8'h00;
            h_crc <= 8'h00;
        end else if (rx_take) begin
            if (idx == 3'd2) t_crc <= m_rx_data;
            if (idx == 3'd5) h_crc <= m_rx_data;
        end
    end
`else
    assign crc_ok = 1'b1;
`endif

    // Data byte capture (CRC bytes are handled above, or discarded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_hi <= 8'h00;
            t_lo <= 8'h00;
            h_hi <= 8'h00;
            h_lo <= 8'h00;
        end else if (rx_take) begin
            case (idx)
                3'd0:    t_hi <= m_rx_data;
                3'd1:    t_lo <= m_rx_data;
                3'd3:    h_hi <= m_rx_data;
                3'd4:    h_lo <= m_rx_data;
                default: ;
            endcase
        end
    end

    // Sequencer. CHECK has no dwell cycle: it is resolved on the edge that
    // samples the read's m_done, so data_valid and the fall of busy appear
    // exactly one cycle after m_done. The CHECK encoding still exists so a
    // corrupted state register falls back to IDLE cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            m_req      <= 1'b0;
            m_rw       <= 1'b0;
            m_wdata    <= 8'h00;
            m_nbytes   <= 3'd0;
            temp_raw   <= 16'h0000;
            hum_raw    <= 16'h0000;
            data_valid <= 1'b0;
            err        <= ERR_NONE;
            idx        <= 3'd0;
            wait_cnt   <= '0;
            to_cnt     <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WR_REQ;
                        busy     <= 1'b1;
                        err      <= ERR_NONE;
                        m_req    <= 1'b1;
                        m_rw     <= 1'b0;
                        m_wdata  <= MEAS_CMD;
                        m_nbytes <= 3'd1;
                    end
                end

                WR_REQ: begin
                    if (m_ack) begin
                        state    <= WR_WAIT;
                        m_req    <= 1'b0;
                        m_wdata  <= 8'h00;
                        m_nbytes <= 3'd0;
                        to_cnt   <= '0;
                    end
                end

                WR_WAIT: begin
                    if (m_nack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= ERR_NACK;
                    end else if (m_done) begin
                        state    <= MEAS_WAIT;
                        wait_cnt <= WC_W'(WAIT_CYCLES - 1);
                    end else if (to_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= ERR_TMO;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                // WAIT_CYCLES cycles here; the read request is raised on the
                // edge that leaves, i.e. WAIT_CYCLES+1 cycles after m_done.
                MEAS_WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= RD_REQ;
                        m_req    <= 1'b1;
                        m_rw     <= 1'b1;
                        m_nbytes <= 3'd6;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                RD_REQ: begin
                    if (m_ack) begin
                        state    <= RD_DATA;
                        m_req    <= 1'b0;
                        m_rw     <= 1'b0;
                        m_nbytes <= 3'd0;
                        idx      <= 3'd0;
                        to_cnt   <= '0;
                    end
                end

                RD_DATA: begin
                    idx <= idx_nxt;
                    if (m_nack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= ERR_NACK;
                    end else if (m_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (idx_nxt != 3'd6) begin
                            err <= ERR_TMO;
                        end else if (crc_ok) begin
                            temp_raw   <= {t_hi, t_lo};
                            hum_raw    <= {h_hi, h_lo};
                            data_valid <= 1'b1;
                        end else begin
                            err <= ERR_CRC;
                        end
                    end else if (to_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= ERR_TMO;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sht40_sequencer.sv
// Self-checking bench for sht40_sequencer: a table of fixed read-backs,
// randomized read-backs scored against a transaction-level model, and
// hand-written error/reset sequences. Inputs are driven and outputs sampled
// on the falling edge.

module tb_sht40_sequencer;

    localparam int WAIT = 10;
    localparam int TMO  = 4095;
`ifdef SHT40_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        m_req;
    logic        m_rw;
    logic [6:0]  m_addr;
    logic [7:0]  m_wdata;
    logic [2:0]  m_nbytes;
    logic        m_ack = 1'b0;
    logic        m_rx_valid = 1'b0;
    logic [7:0]  m_rx_data = 8'h00;
    logic        m_done = 1'b0;
    logic        m_nack = 1'b0;
    logic [15:0] temp_raw;
    logic [15:0] hum_raw;
    logic        data_valid;
    logic [1:0]  err;

    int errs = 0;
    int checks = 0;
    logic [15:0] exp_t = 16'h0000;
    logic [15:0] exp_h = 16'h0000;

    sht40_sequencer #(
        .SENSOR_ADDR   (7'h44),
        .MEAS_CMD      (8'hFD),
        .WAIT_CYCLES   (WAIT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .m_req     (m_req),
        .m_rw      (m_rw),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_nbytes  (m_nbytes),
        .m_ack     (m_ack),
        .m_rx_valid(m_rx_valid),
        .m_rx_data (m_rx_data),
        .m_done    (m_done),
        .m_nack    (m_nack),
        .temp_raw  (temp_raw),
        .hum_raw   (hum_raw),
        .data_valid(data_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [5:0][7:0] b;     // b[0] is the first byte on the bus
        logic [15:0]     et;
        logic [15:0]     eh;
        int              ee;    // expected err with CRC checking built in
    } vec_t;

    vec_t vt[4];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // CRC reference as polynomial division of the augmented message, with the
    // 0xFF init folded into the leading byte.
    function automatic logic [7:0] crc_ref(input logic [15:0] d);
        logic [23:0] v;
        v = {d ^ 16'hFF00, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (v[i]) v = v ^ (24'h000131 << (i - 8));
        return v[7:0];
    endfunction

    function automatic logic [5:0][7:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5);
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    // Acts as the I2C master for one measurement.
    // mode 0: normal read of nb bytes then m_done; 1: NACK on the write;
    // 2: stall after nb bytes (no m_done); 3: reset after 3 read bytes.
    task automatic measure(input logic [5:0][7:0] b, input int nb, input int mode);
        int n;
        bit comb;
        start = 1'b1; step(); start = 1'b0;
        chk("busy_rise", 32'(busy), 1);
        n = 0;
        while (!m_req && n < 20) begin step(); n++; end
        chk("wr_req", 32'(m_req), 1);
        chk("wr_fields", 32'({m_rw, m_addr, m_wdata, m_nbytes}), 32'({1'b0, 7'h44, 8'hFD, 3'd1}));
        step();
        chk("wr_hold", 32'({m_req, m_rw, m_wdata, m_nbytes}), 32'({1'b1, 1'b0, 8'hFD, 3'd1}));
        m_ack = 1'b1; step(); m_ack = 1'b0;
        chk("wr_drop", 32'(m_req), 0);
        step(); step();
        if (mode == 1) begin
            m_nack = 1'b1; step(); m_nack = 1'b0;
            return;
        end
        m_done = 1'b1; step(); m_done = 1'b0;
        n = 1;
        // A start pulse in the middle of the wait must be ignored.
        while (!m_req && n < WAIT + 20) begin
            start = (n == 3);
            step();
            n++;
        end
        start = 1'b0;
        chk("meas_gap", 32'(n), WAIT + 1);
        chk("rd_fields", 32'({m_req, m_rw, m_addr, m_wdata, m_nbytes}),
            32'({1'b1, 1'b1, 7'h44, 8'h00, 3'd6}));
        m_ack = 1'b1; step(); m_ack = 1'b0;
        chk("rd_drop", 32'(m_req), 0);
        n = 1;
        comb = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (mode == 0) repeat ($urandom_range(0, 2)) step();
            comb = (mode == 0) && (i == nb - 1) && ($urandom_range(0, 1) == 1);
            m_rx_valid = 1'b1; m_rx_data = b[i]; m_done = comb;
            step(); n++;
            m_rx_valid = 1'b0; m_done = 1'b0;
            if (mode == 3 && i == 2) begin
                rst_n = 1'b0; step();
                return;
            end
        end
        if (mode == 2) begin
            while (busy && n < 5000) begin step(); n++; end
            chk("tmo_busy", 32'(busy), 0);
            chk("tmo_window", 32'(n >= TMO && n <= TMO + 3), 1);
            return;
        end
        if (!comb) begin
            // Occasionally a stray extra byte, which must be ignored.
            if (nb == 6 && $urandom_range(0, 3) == 0) begin
                m_rx_valid = 1'b1; m_rx_data = 8'h5A; step(); m_rx_valid = 1'b0;
            end
            m_done = 1'b1; step(); m_done = 1'b0;
        end
    endtask

    task automatic check_done(input string tag, input bit dv, input int e);
        chk({tag, "_dv"}, 32'(data_valid), 32'(dv));
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_temp"}, 32'(temp_raw), 32'(exp_t));
        chk({tag, "_hum"}, 32'(hum_raw), 32'(exp_h));
        step();
        chk({tag, "_dv_pulse"}, 32'(data_valid), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, 32'({busy, m_req, m_rw, data_valid}), 0);
        chk({tag, "_req"}, 32'({m_addr, m_wdata, m_nbytes}), 32'({7'h44, 8'h00, 3'd0}));
        chk({tag, "_data"}, 32'({temp_raw, hum_raw}), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        logic [5:0][7:0] rb;
        bit ok;
        int e;
        int n;

        vt[0] = '{b: mk(8'h66, 8'h66, 8'h93, 8'hBE, 8'hEF, 8'h92), et: 16'h6666, eh: 16'hBEEF, ee: 0};
        vt[1] = '{b: mk(8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93), et: 16'hBEEF, eh: 16'h6666, ee: 0};
        vt[2] = '{b: mk(8'h66, 8'h66, 8'h93, 8'hBE, 8'hEF, 8'h93), et: 16'h6666, eh: 16'hBEEF, ee: 2};
        vt[3] = '{b: mk(8'hBE, 8'hEF, 8'h93, 8'h66, 8'h66, 8'h93), et: 16'hBEEF, eh: 16'h6666, ee: 2};

        step(); step();
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        step();
        check_reset_vals("after_reset");

        for (int i = 0; i < 4; i++) begin
            measure(vt[i].b, 6, 0);
            e = CRC_ON ? vt[i].ee : 0;
            if (e == 0) begin exp_t = vt[i].et; exp_h = vt[i].eh; end
            check_done($sformatf("vec%0d", i), e == 0, e);
        end

        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 6; j++) rb[j] = 8'($urandom);
            rb[2] = crc_ref({rb[0], rb[1]});
            rb[5] = crc_ref({rb[3], rb[4]});
            if ($urandom_range(0, 3) == 0)
                rb[$urandom_range(0, 5)] ^= 8'(1 << $urandom_range(0, 7));
            ok = !CRC_ON || (crc_ref({rb[0], rb[1]}) == rb[2] && crc_ref({rb[3], rb[4]}) == rb[5]);
            measure(rb, 6, 0);
            if (ok) begin exp_t = {rb[0], rb[1]}; exp_h = {rb[3], rb[4]}; end
            check_done($sformatf("rnd%0d", k), ok, ok ? 0 : 2);
        end

        measure(vt[1].b, 4, 0);
        check_done("short_read", 1'b0, 3);

        measure(vt[0].b, 6, 1);
        check_done("wr_nack", 1'b0, 1);
        n = 0;
        repeat (20) begin step(); if (m_req) n++; end
        chk("no_read_after_nack", 32'(n), 0);

        measure(vt[0].b, 2, 2);
        chk("tmo_err", 32'(err), 3);
        chk("tmo_data", 32'({temp_raw, hum_raw}), 32'({exp_t, exp_h}));
        measure(vt[0].b, 6, 0);
        exp_t = 16'h6666; exp_h = 16'hBEEF;
        check_done("after_tmo", 1'b1, 0);

        measure(vt[1].b, 6, 3);
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        exp_t = 16'h0000; exp_h = 16'h0000;
        step();
        measure(vt[0].b, 6, 0);
        exp_t = 16'h6666; exp_h = 16'hBEEF;
        check_done("after_rst", 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sht40_sequencer.md
# sht40_sequencer

Measurement sequencer for the SHT40 temperature/humidity sensor, sitting between the system processor logic and the byte-level I2C master. On a `start` pulse it commands the I2C master to write the measurement command, waits the sensor conversion time, then commands a 6-byte read. It checks the CRC of each data word and presents raw temperature and humidity words with a one-cycle valid strobe, or an error code.

## Interface
- `SENSOR_ADDR`, 7'h44, 7-bit I2C address of the sensor.
- `MEAS_CMD`, 8'hFD, measurement command byte (high precision).
- `WAIT_CYCLES`, 200000, clk cycles between write completion and read request (10 ms at 20 MHz).
- `TIMEOUT_CYCLES`, 4095, max clk cycles from master acceptance to `m_done`; counter width is 12 bits.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to run one measurement.
- `busy`  out  1  high from the cycle after an accepted `start` until return to IDLE.
- `m_req`  out  1  transaction request to the I2C master.
- `m_rw`  out  1  0 = write, 1 = read; valid while `m_req` is high.
- `m_addr`  out  7  always `SENSOR_ADDR`.
- `m_wdata`  out  8  write byte; `MEAS_CMD` during the write, 0 otherwise.
- `m_nbytes`  out  3  bytes in the transaction: 1 for the write, 6 for the read.
- `m_ack`  in  1  master accepted the request.
- `m_rx_valid`  in  1  one-cycle strobe that a received byte is on `m_rx_data`.
- `m_rx_data`  in  8  received byte.
- `m_done`  in  1  one-cycle strobe that the transaction ended with a STOP.
- `m_nack`  in  1  one-cycle strobe that the sensor NACKed; the master issues the STOP itself.
- `temp_raw`  out  16  last good temperature word, MSB first on the bus.
- `hum_raw`  out  16  last good humidity word.
- `data_valid`  out  1  one-cycle strobe when `temp_raw`/`hum_raw` update.
- `err`  out  2  0 = none, 1 = NACK, 2 = CRC, 3 = timeout/short read; latched.

## Operation
- States: IDLE, WR_REQ, WR_WAIT, MEAS_WAIT, RD_REQ, RD_DATA, CHECK.
- IDLE: when `start` is high, go to WR_REQ and clear `err` to 0. `start` is ignored in every other state.
- WR_REQ: hold `m_req`=1, `m_rw`=0, `m_nbytes`=1 until `m_ack`; then go to WR_WAIT.
- WR_WAIT: on `m_done`, load the wait counter and go to MEAS_WAIT.
- MEAS_WAIT: count `WAIT_CYCLES`, then go to RD_REQ.
- RD_REQ: hold `m_req`=1, `m_rw`=1, `m_nbytes`=6 until `m_ack`; then go to RD_DATA with the byte index at 0.
- RD_DATA: each `m_rx_valid` stores the byte at the current index and increments the index (0..5). Any `m_rx_valid` after the index reaches 6 is ignored. On `m_done` with index 6, go to CHECK. On `m_done` with index <6, set `err`=3.
- CHECK: bytes 0–1 are temp, byte 2 is its CRC; bytes 3–4 are hum, byte 5 is its CRC. On pass, load `temp_raw`/`hum_raw`, pulse `data_valid`, and return to IDLE.
- CRC: polynomial 0x31, initial value 0xFF, no reflection, no final XOR, computed over the 2 data bytes MSB first. CRC of 0xBE,0xEF is 0x92.
- Any error: set `err`, return to IDLE, leave `temp_raw`/`hum_raw` unchanged, no `data_valid` pulse.
- Error sources:
  - `m_nack` in WR_WAIT or RD_DATA sets `err`=1.
  - Timeout counter reaching `TIMEOUT_CYCLES` in WR_WAIT or RD_DATA sets `err`=3.
  - CRC mismatch on either word sets `err`=2.
- Simultaneous events: `m_nack` wins over `m_done` in the same cycle. `m_rx_valid` and `m_done` in the same cycle: the byte is stored first, then the index is checked.

## Timing
- Reset values: `busy`=0, `m_req`=0, `m_rw`=0, `m_addr`=`SENSOR_ADDR`, `m_wdata`=0, `m_nbytes`=0, `temp_raw`=0, `hum_raw`=0, `data_valid`=0, `err`=0; state goes to IDLE.
- Reset asserted mid-transaction aborts immediately. Recovery of the bus is the master's responsibility.
- `m_req` rises the cycle after entering WR_REQ/RD_REQ and falls the cycle after `m_ack` is sampled high. Its request fields are stable while it is high.
- The first read request is issued exactly `WAIT_CYCLES`+1 cycles after the write's `m_done`.
- `data_valid` asserts one cycle after the read's `m_done`; `busy` falls in the same cycle.
- The timeout counter runs only in WR_WAIT and RD_DATA and restarts on entry to each.

## Configuration
- `SHT40_CRC_CHECK_EN` defined: CRC checked as described; a mismatch gives `err`=2.
- Not defined: no CRC logic; bytes 2 and 5 are discarded, CHECK always passes, and `err` never takes value 2.

## Test plan
- Reset, then `start` with master model returning 0x66,0x66,0x93 (temp CRC correct), 0xBE,0xEF,0x92 → write of 0xFD to 0x44 and a 6-byte read; `temp_raw`=0x6666, `hum_raw`=0xBEEF, one `data_valid` pulse, `err`=0.
- Gap between the write's `m_done` and the read's `m_req` rising → exactly `WAIT_CYCLES`+1 cycles (check with `WAIT_CYCLES`=10).
- `m_nack` on the write → `err`=1, no read issued, outputs unchanged, `busy` low the next cycle.
- Last byte corrupted to 0x93 → `err`=2 with the macro defined; with the macro undefined → `data_valid` pulses and `err`=0.
- Master stalls with no `m_done` → `err`=3 after `TIMEOUT_CYCLES`; a second `start` after this completes normally and clears `err`.
- `rst_n` pulsed low during RD_DATA → all outputs at reset values, state IDLE; `start` pulses while `busy` is high are ignored.
